// File: rtl/serial2parallel.sv
// serial2parallel: MSB-first serial frame assembler with framing checks, one-cycle result
// and error pulses, and a saturating good-frame counter.
module serial2parallel #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_start,
  input  logic             serial_in,
  input  logic             serial_end,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             frame_error,
  output logic [7:0]       frame_count
);
  localparam int CW = $clog2(WIDTH);
  localparam int SW = WIDTH - 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    sr_q, sr_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             ov_q, ov_d, fe_q, fe_d;
  logic [7:0]       fc_q, fc_d;
  logic             last;
  // The shift register holds only the first WIDTH-1 bits; the LSB arrives with serial_end.
  assign last = cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    po_d    = po_q;
    ov_d    = 1'b0;
    fe_d    = 1'b0;
    fc_d    = fc_q;
    if (state_q == IDLE) begin
      if (serial_start) begin
        if (serial_end) fe_d = 1'b1;
        else begin
          sr_d    = SW'(serial_in);
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
    end else if (serial_start) begin
      fe_d = 1'b1;
      if (serial_end) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        sr_d  = SW'(serial_in);
        cnt_d = CW'(1);
      end
    end else if (serial_end || last) begin
      state_d = IDLE;
      cnt_d   = '0;
      if (serial_end && last) begin
        po_d = {sr_q, serial_in};
        ov_d = 1'b1;
        fc_d = fc_q + {7'd0, fc_q != 8'hFF};
      end else fe_d = 1'b1;
    end else begin
      sr_d  = SW'({sr_q, serial_in});
      cnt_d = cnt_q + CW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      po_q    <= '0;
      ov_q    <= 1'b0;
      fe_q    <= 1'b0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      po_q    <= po_d;
      ov_q    <= ov_d;
      fe_q    <= fe_d;
      fc_q    <= fc_d;
    end
  end
  assign parallel_out = po_q;
  assign out_valid    = ov_q;
  assign frame_error  = fe_q;
  assign frame_count  = fc_q;
endmodule

// File: tb/tb_serial2parallel.sv
// tb_serial2parallel: table-driven frames plus hand sequences, checked through a scoreboard queue.
module tb_serial2parallel;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_start = 1'b0, serial_in = 1'b0, serial_end = 1'b0;
  logic [7:0] parallel_out;
  logic       out_valid, frame_error;
  logic [7:0] frame_count;
  serial2parallel #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .serial_start(serial_start), .serial_in(serial_in),
    .serial_end(serial_end), .parallel_out(parallel_out), .out_valid(out_valid),
    .frame_error(frame_error), .frame_count(frame_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] data;
    int         nbits;
    int         end_at;
    bit         exp_err;
    logic [7:0] exp_word;
    logic [7:0] exp_cnt;
  } vec_t;
  typedef struct {
    bit         is_err;
    logic [7:0] word;
    logic [7:0] cnt;
  } exp_t;
  exp_t       sb[$];
  vec_t       tbl[8];
  int         checks = 0, errors = 0;
  int         cyc = 0, last_ok = 0, prev_ok = 0, err_pulses = 0;
  logic [7:0] mdl_word = 8'h00, mdl_cnt = 8'h00;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && (out_valid || frame_error)) begin
      exp_t e;
      if (out_valid) begin
        prev_ok = last_ok;
        last_ok = cyc;
      end
      if (frame_error) err_pulses++;
      chk("exclusive_pulses", {31'd0, out_valid & frame_error}, 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got out_valid=%0b frame_error=%0b expected none at cycle %0d",
                 out_valid, frame_error, cyc);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {31'd0, frame_error}, {31'd0, e.is_err});
        chk("parallel_out", {24'd0, parallel_out}, {24'd0, e.word});
        chk("frame_count", {24'd0, frame_count}, {24'd0, e.cnt});
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] data, input int nbits, input int end_at, input bit exp_pulse);
    for (int i = 0; i < nbits; i++) begin
      serial_start = (i == 0);
      serial_in    = data[7-i];
      serial_end   = ((i + 1) == end_at);
      tick();
    end
    serial_start = 1'b0;
    serial_in    = 1'b0;
    serial_end   = 1'b0;
    chk("pulse_latency", {31'd0, out_valid | frame_error}, {31'd0, exp_pulse});
  endtask
  task automatic push_ok(input logic [7:0] w);
    mdl_word = w;
    mdl_cnt  = (mdl_cnt == 8'hFF) ? 8'hFF : mdl_cnt + 8'd1;
    sb.push_back('{1'b0, w, mdl_cnt});
  endtask
  task automatic push_err();
    sb.push_back('{1'b1, mdl_word, mdl_cnt});
  endtask
  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    chk("scoreboard_drained", sb.size(), 0);
  endtask
  initial begin
    tbl[0] = '{8'hD3, 8, 8, 1'b0, 8'hD3, 8'd1};
    tbl[1] = '{8'hD3, 5, 5, 1'b1, 8'hD3, 8'd1};
    tbl[2] = '{8'hFF, 8, 0, 1'b1, 8'hD3, 8'd1};
    tbl[3] = '{8'h3C, 8, 8, 1'b0, 8'h3C, 8'd2};
    tbl[4] = '{8'h80, 1, 1, 1'b1, 8'h3C, 8'd2};
    tbl[5] = '{8'h5A, 8, 8, 1'b0, 8'h5A, 8'd3};
    tbl[6] = '{8'h96, 3, 3, 1'b1, 8'h5A, 8'd3};
    tbl[7] = '{8'h01, 8, 8, 1'b0, 8'h01, 8'd4};
    tick();
    tick();
    chk("rst_parallel_out", {24'd0, parallel_out}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_frame_error", {31'd0, frame_error}, 0);
    chk("rst_frame_count", {24'd0, frame_count}, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{tbl[i].exp_err, tbl[i].exp_word, tbl[i].exp_cnt});
      send(tbl[i].data, tbl[i].nbits, tbl[i].end_at, 1'b1);
    end
    mdl_word = tbl[7].exp_word;
    mdl_cnt  = tbl[7].exp_cnt;
    drain();
    begin
      int e0;
      e0 = err_pulses;
      push_ok(8'hD3);
      push_ok(8'h5A);
      send(8'hD3, 8, 8, 1'b1);
      send(8'h5A, 8, 8, 1'b1);
      drain();
      chk("b2b_spacing", last_ok - prev_ok, 8);
      chk("b2b_no_error", err_pulses - e0, 0);
    end
    push_err();
    push_ok(8'hA5);
    send(8'hE0, 3, 0, 1'b0);
    send(8'hA5, 8, 8, 1'b1);
    drain();
    send(8'hD3, 3, 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_parallel_out", {24'd0, parallel_out}, 0);
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_frame_error", {31'd0, frame_error}, 0);
    chk("midrst_frame_count", {24'd0, frame_count}, 0);
    mdl_word = 8'h00;
    mdl_cnt  = 8'h00;
    push_ok(8'hD3);
    send(8'hD3, 8, 8, 1'b1);
    drain();
    for (int i = 0; i < 256; i++) begin
      push_ok(8'(i));
      send(8'(i), 8, 8, 1'b1);
    end
    drain();
    chk("saturated_count", {24'd0, frame_count}, 255);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
